// File: rtl/dragon_step_scheduler_if.sv
// Signal bundle between the dragon step scheduler and the logic around it.
// The frame timing, head block and renderer/collision side use the master modport.
interface dragon_step_scheduler_if #(
    parameter int MAX_SEGMENTS = 8,
    parameter int LEN_W        = 4
);
    logic                      vsync;
    logic                      enable;
    logic [5:0]                period;
    logic                      grow_req;
    logic [7:0]                head_pos;
    logic                      head_done;
    logic                      move_strobe;
    logic [8*MAX_SEGMENTS-1:0] seg_pos;
    logic [MAX_SEGMENTS-1:0]   seg_valid;
    logic [LEN_W-1:0]          length;
    logic                      busy;
    logic                      step_done;
    logic                      timeout_err;

    modport master (
        output vsync,
        output enable,
        output period,
        output grow_req,
        output head_pos,
        output head_done,
        input  move_strobe,
        input  seg_pos,
        input  seg_valid,
        input  length,
        input  busy,
        input  step_done,
        input  timeout_err
    );

    modport slave (
        input  vsync,
        input  enable,
        input  period,
        input  grow_req,
        input  head_pos,
        input  head_done,
        output move_strobe,
        output seg_pos,
        output seg_valid,
        output length,
        output busy,
        output step_done,
        output timeout_err
    );
endinterface

// File: rtl/dragon_step_scheduler.sv
// Paces dragon steps off vsync, strobes the head block, then ripples the new
// head position down the body array one segment per clock.
//   state     | meaning
//   IDLE      | counting vsync rises toward the next step
//   STROBE    | move_strobe to the head block
//   WAIT_HEAD | waiting for head_done, bounded by wait_cnt
//   SHIFT     | copying seg[idx-1] into seg[idx], head written last
//   DONE      | step_done pulse
module dragon_step_scheduler #(
    parameter int MAX_SEGMENTS = 8,
    parameter int INIT_LEN     = 3,
    parameter int LEN_W        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    dragon_step_scheduler_if.slave bus
);

    localparam int IDX_W = (MAX_SEGMENTS > 1) ? $clog2(MAX_SEGMENTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_HEAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    vsync_q;
    logic [5:0]              frame_cnt_q, frame_cnt_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    grow_pend_q, grow_pend_d;
    logic [LEN_W-1:0]        length_q, length_d;
    logic [LEN_W-1:0]        idx_q, idx_d;
    logic [7:0]              head_lat_q, head_lat_d;
    logic [7:0]              seg_q [MAX_SEGMENTS];
    logic [7:0]              seg_d [MAX_SEGMENTS];
    logic [MAX_SEGMENTS-1:0] seg_valid_q, seg_valid_d;
    logic                    move_strobe_q, move_strobe_d;
    logic                    busy_q, busy_d;
    logic                    step_done_q, step_done_d;
    logic                    timeout_err_q, timeout_err_d;

    logic                    rise;
    logic                    head_timeout;
    logic [IDX_W-1:0]        sel_dst;
    logic [IDX_W-1:0]        sel_src;

    assign rise         = bus.vsync & ~vsync_q;
    assign head_timeout = (state_q == S_WAIT_HEAD) && !bus.head_done && (wait_cnt_q == 4'd15);
    assign sel_dst      = idx_q[IDX_W-1:0];
    assign sel_src      = sel_dst - IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            vsync_q       <= 1'b0;
            frame_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            grow_pend_q   <= 1'b0;
            length_q      <= LEN_W'(INIT_LEN);
            idx_q         <= '0;
            head_lat_q    <= '0;
            move_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            step_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < MAX_SEGMENTS; i++) begin
                seg_q[i]       <= '0;
                seg_valid_q[i] <= (i < INIT_LEN);
            end
        end else begin
            state_q       <= state_d;
            vsync_q       <= bus.vsync;
            frame_cnt_q   <= frame_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            grow_pend_q   <= grow_pend_d;
            length_q      <= length_d;
            idx_q         <= idx_d;
            head_lat_q    <= head_lat_d;
            seg_q         <= seg_d;
            seg_valid_q   <= seg_valid_d;
            move_strobe_q <= move_strobe_d;
            busy_q        <= busy_d;
            step_done_q   <= step_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable && rise && (frame_cnt_q == bus.period)) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                state_d = S_WAIT_HEAD;
            end
            S_WAIT_HEAD: begin
                if (bus.head_done) begin
                    state_d = S_SHIFT;
                end else if (wait_cnt_q == 4'd15) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        grow_pend_d = grow_pend_q;
        length_d    = length_q;
        idx_d       = idx_q;
        head_lat_d  = head_lat_q;
        seg_d       = seg_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.enable) begin
                    frame_cnt_d = '0;
                end else if (rise) begin
                    frame_cnt_d = (frame_cnt_q == bus.period) ? 6'd0 : frame_cnt_q + 6'd1;
                end
            end
            S_STROBE: begin
                wait_cnt_d = '0;
            end
            S_WAIT_HEAD: begin
                if (bus.head_done) begin
                    head_lat_d  = bus.head_pos;
                    grow_pend_d = 1'b0;
                    // growing shifts one extra slot, so the new tail copies the old tail
                    if (grow_pend_q && (length_q < LEN_W'(MAX_SEGMENTS))) begin
                        length_d = length_q + LEN_W'(1);
                        idx_d    = length_q;
                    end else begin
                        idx_d    = length_q - LEN_W'(1);
                    end
                end else if (wait_cnt_q != 4'd15) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_SHIFT: begin
                if (idx_q != '0) begin
                    seg_d[sel_dst] = seg_q[sel_src];
                    idx_d          = idx_q - LEN_W'(1);
                end else begin
                    seg_d[0] = head_lat_q;
                end
            end
            default: begin
            end
        endcase

        // a request arriving alongside consumption stays pending for the next step
        if (bus.grow_req) begin
            grow_pend_d = 1'b1;
        end
    end

    always_comb begin
        move_strobe_d = (state_d == S_STROBE);
        busy_d        = (state_d != S_IDLE);
        step_done_d   = (state_d == S_DONE);
        timeout_err_d = head_timeout;
        seg_valid_d   = '0;
        for (int i = 0; i < MAX_SEGMENTS; i++) begin
            seg_valid_d[i] = (i < int'(length_d));
        end
    end

    for (genvar g = 0; g < MAX_SEGMENTS; g++) begin : g_seg_out
        assign bus.seg_pos[8*g +: 8] = seg_q[g];
    end

    assign bus.seg_valid   = seg_valid_q;
    assign bus.length      = length_q;
    assign bus.move_strobe = move_strobe_q;
    assign bus.busy        = busy_q;
    assign bus.step_done   = step_done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/dragon_step_scheduler.md
# dragon_step_scheduler

Sequencer that paces the dragon's movement and propagates each head step down the body. It counts vsync frames against a programmable period and issues a one-cycle move strobe to the head-movement block. It then captures the new head position and shifts it into the body-segment position array one segment per cycle, growing the body on request. It sits between the frame-timing logic, the dragon head block and the renderer/collision logic that consume the segment positions.

## Interface
- MAX_SEGMENTS, 8: capacity of the segment array, head included; range 2..15.
- INIT_LEN, 3: body length after reset, head included; range 1..MAX_SEGMENTS.
- LEN_W, 4: width of `length`; must satisfy 2^LEN_W > MAX_SEGMENTS.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-low; clock clk.
- vsync  in  1  frame sync, asynchronous to game logic only by phase; single-clock domain.
- enable  in  1  game running; low holds the scheduler in IDLE.
- period  in  6  frames between steps minus one: a step occurs every period+1 vsync rising edges.
- grow_req  in  1  one-cycle request to lengthen the body by one segment.
- head_pos  in  8  {x[3:0], y[3:0]} from head block; sampled only when head_done=1.
- head_done  in  1  head block has a new head_pos for this step.
- move_strobe  out  1  one-cycle pulse commanding the head block to take one step.
- seg_pos  out  8*MAX_SEGMENTS  flattened positions; segment i at [8i+7:8i]; segment 0 is the head.
- seg_valid  out  MAX_SEGMENTS  thermometer mask; bit i = (i < length).
- length  out  LEN_W  current segment count.
- busy  out  1  high in every state except IDLE.
- step_done  out  1  one-cycle pulse when a step has fully propagated.
- timeout_err  out  1  one-cycle pulse when head_done was not seen in time.

## Operation
- Edge detect: vsync_q registers vsync. rise = vsync & ~vsync_q.
- States: IDLE, STROBE, WAIT_HEAD, SHIFT, DONE.
- IDLE, enable=0: frame_cnt cleared to 0, no transitions.
- IDLE, enable=1, rise:
  - frame_cnt==period: frame_cnt<=0 and go to STROBE.
  - otherwise: frame_cnt<=frame_cnt+1.
- Rises outside IDLE are ignored and frame_cnt is held.
- STROBE: move_strobe=1 for exactly this cycle. Clear wait_cnt. Go to WAIT_HEAD.
- WAIT_HEAD, head_done=1: latch head_pos into head_lat.
  - If grow_pend=1 and length<MAX_SEGMENTS: length<=length+1 and idx<=length (old value).
  - Otherwise: idx<=length-1.
  - In both cases grow_pend<=0. Go to SHIFT.
- WAIT_HEAD, head_done=0: wait_cnt increments. At wait_cnt==15 with no head_done, pulse timeout_err, go to IDLE, and leave seg_pos, length and grow_pend untouched.
- SHIFT, idx>0: seg[idx]<=seg[idx-1], idx<=idx-1.
- SHIFT, idx==0: seg[0]<=head_lat, go to DONE.
- DONE: step_done=1 for one cycle, then IDLE.
- grow_pend is set by grow_req in any state. A grow_req in the same cycle as consumption in WAIT_HEAD wins, so grow_pend ends at 1. A grow at length==MAX_SEGMENTS is dropped silently.
- Positions of segments at index >= length hold stale data and are masked by seg_valid. A newly grown tail is a copy of the old tail.
- enable falling mid-step does not abort; the step completes.
- Positions are copied verbatim; no arithmetic on coordinates.

## Timing
- Reset values:
  - state=IDLE; frame_cnt=0; wait_cnt=0; grow_pend=0; vsync_q=0.
  - seg_pos all 0; length=INIT_LEN; seg_valid=(1<<INIT_LEN)-1.
  - move_strobe=0, busy=0, step_done=0, timeout_err=0.
- Reset is synchronous and overrides everything, including mid-SHIFT.
- move_strobe is high the cycle after the clock edge that sampled the period-completing rise.
- Step latency from head_done to step_done is L+1 cycles, where L = length after any growth: L-1 copy cycles + 1 head write + DONE.
- With no growth, seg_pos is fully updated at the edge that enters DONE.
- All outputs are registered.

## Test plan
- Reset: reset=0 for 2 cycles with INIT_LEN=3 -> length=3, seg_valid=8'b00000111, seg_pos=0, busy=0, move_strobe=0.
- Pacing: period=2, enable=1, 9 vsync rises -> exactly 3 move_strobe pulses, on rises 3, 6 and 9.
- Shift: seg0..2={0x11,0x12,0x13}, head_done with head_pos=0x21 -> after step_done seg0..2={0x21,0x11,0x12}; head_done to step_done = 4 cycles.
- Grow: grow_req while IDLE at length=3, then head_pos=0x22 -> length=4, seg_valid=4'b1111, seg3=old seg2. Repeat at length=MAX_SEGMENTS -> length unchanged, grow_pend cleared.
- Timeout: move_strobe issued, head_done held 0 -> timeout_err pulse after 16 WAIT_HEAD cycles, state IDLE, seg_pos unchanged, pending grow retained.
- Disruption: enable=0 mid-SHIFT -> step completes. Then reset=0 mid-SHIFT -> all reset values on the next cycle, vsync rises ignored while enable=0.
